// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback and drives
// the ALU select, operand muxes and datapath strobes for one instruction at a time.
module mips_mc_control #(
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_sel,
    output logic [3:0] alu_sel,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        JUMP      = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic       ext;
        logic [3:0] sel;
        logic       illegal;
        logic       done;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t next_state;
    ctrl_t  ctrl_q;
    logic   live;
    logic   dec_bad;

    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:                 return R_EXEC;
            OP_LW, OP_SW:             return MEM_ADDR;
            OP_BEQ, OP_BNE:           return BRANCH;
            OP_J:                     return JUMP;
            6'b001000, 6'b001100, 6'b001101,
            6'b001010, 6'b001111:     return I_EXEC;
            default:                  return FETCH;
        endcase
    endfunction

    // Returns {unknown_funct, alu_sel}.
    function automatic logic [4:0] r_decode(input logic [5:0] fn);
        case (fn)
            6'b100000: return 5'b0_0000;
            6'b100010: return 5'b0_0111;
            6'b100100: return 5'b0_0001;
            6'b100101: return 5'b0_0010;
            6'b100111: return 5'b0_0011;
            6'b101010: return 5'b0_0100;
            6'b000000: return 5'b0_0101;
            6'b000010: return 5'b0_0110;
            6'b011000: return MUL_EN ? 5'b0_1000 : 5'b1_0000;
            default:   return 5'b1_0000;
        endcase
    endfunction

    // Returns {ext_sel, alu_sel}.
    function automatic logic [4:0] i_decode(input logic [5:0] op);
        case (op)
            6'b001100: return 5'b1_0001;
            6'b001101: return 5'b1_0010;
            6'b001010: return 5'b0_0100;
            6'b001111: return 5'b0_1001;
            default:   return 5'b0_0000;
        endcase
    endfunction

    function automatic ctrl_t outs_for(input state_t s, input logic [5:0] op, input logic [5:0] fn);
        ctrl_t      c;
        logic [4:0] rd;
        logic [4:0] id;
        logic       is_shift;
        c        = '0;
        rd       = r_decode(fn);
        id       = i_decode(op);
        is_shift = (fn == 6'b000000) || (fn == 6'b000010);
        case (s)
            FETCH:     begin c.ir_write = 1'b1; c.pc_en = 1'b1; c.b = 2'b01; end
            DECODE:    c.b = 2'b11;
            MEM_ADDR:  begin c.a = 2'b01; c.b = 2'b10; end
            MEM_READ:  c.iord = 1'b1;
            MEM_WB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
            MEM_WRITE: begin c.iord = 1'b1; c.mem_write = 1'b1; c.done = 1'b1; end
            R_EXEC: begin
                c.a       = is_shift ? 2'b10 : 2'b01;
                c.b       = is_shift ? 2'b10 : 2'b00;
                c.sel     = rd[3:0];
                c.illegal = rd[4];
            end
            R_WB: begin
                c.reg_dst   = 1'b1;
                c.sel       = rd[3:0];
                c.reg_write = !rd[4];
                c.done      = 1'b1;
            end
            BRANCH:    begin c.a = 2'b01; c.sel = 4'b0111; c.pc_src = 2'b01; c.done = 1'b1; end
            I_EXEC:    begin c.a = 2'b01; c.b = 2'b10; c.ext = id[4]; c.sel = id[3:0]; end
            I_WB:      begin c.reg_write = 1'b1; c.sel = id[3:0]; c.done = 1'b1; end
            JUMP:      begin c.pc_src = 2'b10; c.pc_en = 1'b1; c.done = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        next_state = FETCH;
        case (state_q)
            FETCH:    next_state = DECODE;
            DECODE:   next_state = decode_target(opcode);
            MEM_ADDR: next_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ: next_state = MEM_WB;
            R_EXEC:   next_state = R_WB;
            I_EXEC:   next_state = I_WB;
            default:  next_state = FETCH;
        endcase
    end

    // Outputs are registered from the state being entered; funct/opcode are already valid then.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            ctrl_q  <= outs_for(FETCH, opcode, funct);
        end else begin
            state_q <= next_state;
            ctrl_q  <= outs_for(next_state, opcode, funct);
        end
    end

    // The opcode only lands in the IR at the end of FETCH, so the DECODE trap is combinational.
    assign live    = !rst && (state_q <= JUMP);
    assign dec_bad = (state_q == DECODE) && (decode_target(opcode) == FETCH);

    assign pc_en      = live && ((state_q == BRANCH) ? ((opcode == OP_BEQ) ? zero : !zero) : ctrl_q.pc_en);
    assign ir_write   = live && ctrl_q.ir_write;
    assign mem_write  = live && ctrl_q.mem_write;
    assign reg_write  = live && ctrl_q.reg_write;
    assign illegal    = live && (ctrl_q.illegal || dec_bad);
    assign instr_done = live && (ctrl_q.done || dec_bad);
    assign pc_src     = ctrl_q.pc_src;
    assign iord       = ctrl_q.iord;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src_a  = ctrl_q.a;
    assign alu_src_b  = ctrl_q.b;
    assign ext_sel    = ctrl_q.ext;
    assign alu_sel    = ctrl_q.sel;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: directed and random instructions against a per-instruction
// cycle-plan model, checking a MUL_EN=1 and a MUL_EN=0 instance side by side.
module tb_mips_mc_control;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic       ext;
        logic [3:0] sel;
        logic       illegal;
        logic       done;
    } outs_t;

    typedef struct {
        int    st;
        outs_t o;
        bit    br;
        bit    br_inv;
    } step_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       pc_en_m, iord_m, mem_write_m, ir_write_m, reg_dst_m, mem_to_reg_m, reg_write_m, ext_sel_m, illegal_m, done_m;
    logic [1:0] pc_src_m, a_m, b_m;
    logic [3:0] sel_m, state_m;
    logic       pc_en_n, iord_n, mem_write_n, ir_write_n, reg_dst_n, mem_to_reg_n, reg_write_n, ext_sel_n, illegal_n, done_n;
    logic [1:0] pc_src_n, a_n, b_n;
    logic [3:0] sel_n, state_n;
    outs_t      obs_m, obs_n;

    int checks = 0;
    int errors = 0;
    step_t plan[$];

    logic [5:0] r_functs [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h18, 6'h00, 6'h02};
    logic [3:0] r_sels   [9] = '{4'd0, 4'd7, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6};
    logic [5:0] i_ops    [5] = '{6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f};
    logic [3:0] i_sels   [5] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd9};
    logic       i_exts   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    mips_mc_control #(.MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en_m), .pc_src(pc_src_m), .iord(iord_m), .mem_write(mem_write_m),
        .ir_write(ir_write_m), .reg_dst(reg_dst_m), .mem_to_reg(mem_to_reg_m),
        .reg_write(reg_write_m), .alu_src_a(a_m), .alu_src_b(b_m), .ext_sel(ext_sel_m),
        .alu_sel(sel_m), .illegal(illegal_m), .instr_done(done_m), .state(state_m)
    );

    mips_mc_control #(.MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en_n), .pc_src(pc_src_n), .iord(iord_n), .mem_write(mem_write_n),
        .ir_write(ir_write_n), .reg_dst(reg_dst_n), .mem_to_reg(mem_to_reg_n),
        .reg_write(reg_write_n), .alu_src_a(a_n), .alu_src_b(b_n), .ext_sel(ext_sel_n),
        .alu_sel(sel_n), .illegal(illegal_n), .instr_done(done_n), .state(state_n)
    );

    assign obs_m = {pc_en_m, pc_src_m, iord_m, mem_write_m, ir_write_m, reg_dst_m, mem_to_reg_m,
                    reg_write_m, a_m, b_m, ext_sel_m, sel_m, illegal_m, done_m};
    assign obs_n = {pc_en_n, pc_src_n, iord_n, mem_write_n, ir_write_n, reg_dst_n, mem_to_reg_n,
                    reg_write_n, a_n, b_n, ext_sel_n, sel_n, illegal_n, done_n};

    function automatic bit is_legal_op(input logic [5:0] op);
        if (op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02}) return 1'b1;
        foreach (i_ops[k]) if (i_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void add(input int st, input outs_t o, input bit br, input bit inv);
        step_t s;
        s.st = st; s.o = o; s.br = br; s.br_inv = inv;
        plan.push_back(s);
    endfunction

    // Cycle-by-cycle expectation for one whole instruction, from the instruction class tables.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn, input bit mul_en);
        outs_t o;
        bit    hit;
        logic [3:0] sel;
        plan.delete();
        o = '0; o.ir_write = 1'b1; o.pc_en = 1'b1; o.b = 2'b01;
        add(0, o, 0, 0);
        o = '0; o.b = 2'b11;
        if (!is_legal_op(op)) begin
            o.illegal = 1'b1; o.done = 1'b1;
            add(1, o, 0, 0);
            return;
        end
        add(1, o, 0, 0);
        if (op == 6'h00) begin
            hit = 1'b0; sel = 4'd0;
            foreach (r_functs[k]) if (r_functs[k] == fn) begin hit = 1'b1; sel = r_sels[k]; end
            if (fn == 6'h18 && !mul_en) begin hit = 1'b0; sel = 4'd0; end
            o = '0;
            o.a = (fn == 6'h00 || fn == 6'h02) ? 2'b10 : 2'b01;
            o.b = (fn == 6'h00 || fn == 6'h02) ? 2'b10 : 2'b00;
            o.sel = sel; o.illegal = !hit;
            add(6, o, 0, 0);
            o = '0; o.reg_dst = 1'b1; o.sel = sel; o.reg_write = hit; o.done = 1'b1;
            add(7, o, 0, 0);
        end else if (op == 6'h23 || op == 6'h2b) begin
            o = '0; o.a = 2'b01; o.b = 2'b10;
            add(2, o, 0, 0);
            if (op == 6'h23) begin
                o = '0; o.iord = 1'b1;
                add(3, o, 0, 0);
                o = '0; o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.done = 1'b1;
                add(4, o, 0, 0);
            end else begin
                o = '0; o.iord = 1'b1; o.mem_write = 1'b1; o.done = 1'b1;
                add(5, o, 0, 0);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            o = '0; o.a = 2'b01; o.sel = 4'd7; o.pc_src = 2'b01; o.done = 1'b1;
            add(8, o, 1, op == 6'h05);
        end else if (op == 6'h02) begin
            o = '0; o.pc_src = 2'b10; o.pc_en = 1'b1; o.done = 1'b1;
            add(11, o, 0, 0);
        end else begin
            foreach (i_ops[k]) if (i_ops[k] == op) begin
                o = '0; o.a = 2'b01; o.b = 2'b10; o.sel = i_sels[k]; o.ext = i_exts[k];
                add(9, o, 0, 0);
                o = '0; o.reg_write = 1'b1; o.sel = i_sels[k]; o.done = 1'b1;
                add(10, o, 0, 0);
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input int exp_st, input outs_t exp_o,
                               input logic [3:0] act_st, input outs_t act_o);
        checks++;
        assert (act_st === 4'(exp_st)) else begin
            errors++;
            $error("[TB] FAIL %s state observed=%0d expected=%0d", tag, act_st, exp_st);
        end
        checks++;
        assert (act_o === exp_o) else begin
            errors++;
            $error("[TB] FAIL %s outputs observed=%05h expected=%05h", tag, act_o, exp_o);
        end
    endtask

    // Starts just after a rising edge; runs ncyc cycles of the instruction (all if ncyc < 0).
    task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [5:0] fn,
                                 input int zmode, input int ncyc);
        step_t pm[$];
        step_t pn[$];
        int    n;
        build(op, fn, 1'b1); pm = plan;
        build(op, fn, 1'b0); pn = plan;
        n = (ncyc < 0 || ncyc > pm.size()) ? pm.size() : ncyc;
        for (int i = 0; i < n; i++) begin
            outs_t em;
            outs_t en;
            #1;
            opcode = op;
            funct  = fn;
            zero   = (zmode == 0) ? 1'($urandom_range(0, 1)) : (zmode == 2);
            #1;
            em = pm[i].o;
            en = pn[i].o;
            if (pm[i].br) em.pc_en = pm[i].br_inv ? !zero : zero;
            if (pn[i].br) en.pc_en = pn[i].br_inv ? !zero : zero;
            checkOutput({tag, "/mul"}, pm[i].st, em, state_m, obs_m);
            checkOutput({tag, "/nomul"}, pn[i].st, en, state_n, obs_n);
            @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        outs_t      ro;
        int         pick;
        logic [5:0] op;
        logic [5:0] fn;

        rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        ro = '0; ro.b = 2'b01;
        checkOutput("reset/mul", 0, ro, state_m, obs_m);
        checkOutput("reset/nomul", 0, ro, state_n, obs_n);
        @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus("sub", 6'h00, 6'h22, 0, -1);
        applyStimulus("lw", 6'h23, 6'h15, 0, -1);
        applyStimulus("sw", 6'h2b, 6'h3c, 0, -1);

        // Reset held for three cycles while in MEM_READ.
        applyStimulus("lw_pre", 6'h23, 6'h00, 0, 3);
        #1 rst = 1'b1;
        #1;
        ro = '0; ro.iord = 1'b1;
        checkOutput("rst_in_memread", 3, ro, state_m, obs_m);
        repeat (2) begin
            @(posedge clk);
            #2;
            ro = '0; ro.b = 2'b01;
            checkOutput("rst_held", 0, ro, state_m, obs_m);
            checkOutput("rst_held_nm", 0, ro, state_n, obs_n);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus("after_rst", 6'h00, 6'h25, 0, -1);

        applyStimulus("beq_z1", 6'h04, 6'h11, 2, -1);
        applyStimulus("beq_z0", 6'h04, 6'h11, 1, -1);
        applyStimulus("bne_z1", 6'h05, 6'h07, 2, -1);
        applyStimulus("bne_z0", 6'h05, 6'h07, 1, -1);
        applyStimulus("sll", 6'h00, 6'h00, 0, -1);
        applyStimulus("srl", 6'h00, 6'h02, 0, -1);
        applyStimulus("lui", 6'h0f, 6'h2a, 0, -1);
        applyStimulus("andi", 6'h0c, 6'h01, 0, -1);
        applyStimulus("illegal_op", 6'h3f, 6'h20, 0, -1);
        applyStimulus("mul", 6'h00, 6'h18, 0, -1);
        applyStimulus("bad_funct", 6'h00, 6'h3f, 0, -1);
        applyStimulus("j", 6'h02, 6'h0b, 0, -1);

        for (int k = 0; k < 80; k++) begin
            pick = $urandom_range(0, 11);
            fn   = 6'($urandom_range(0, 63));
            case (pick)
                0:       op = 6'h00;
                1, 2:    begin op = 6'h00; fn = r_functs[$urandom_range(0, 8)]; end
                3:       op = 6'h23;
                4:       op = 6'h2b;
                5:       op = 6'h04;
                6:       op = 6'h05;
                7:       op = 6'h02;
                8, 9:    op = i_ops[$urandom_range(0, 4)];
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (is_legal_op(op)) op = 6'($urandom_range(0, 63));
                end
            endcase
            applyStimulus("random", op, fn, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
